mips_result_checker: RTL

Synthesizable end-of-run checker for the MIPS pipeline, the hardware successor to the per-cycle console monitor. It counts cycles from `start`, waits for `halt` or a cycle timeout, lets the pipeline drain, then scans a parametrised set of register-file entries and data-memory words through debug read ports. Each value is compared against an expected-value table with per-entry don't-care masking. Result is a latched pass/fail verdict with diagnostics, usable on FPGA LEDs or from a bench.

---
 rtl/mips_pkg.sv | 16 +
 rtl/chk_compare_stage.sv | 65 ++++++
 rtl/mips_result_checker.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS checker state encodings and debug address widths
package mips_pkg;

    typedef enum logic [2:0] {
        CHK_IDLE   = 3'd0,
        CHK_RUN    = 3'd1,
        CHK_SETTLE = 3'd2,
        CHK_SCAN   = 3'd3,
        CHK_FLUSH  = 3'd4,
        CHK_DONE   = 3'd5
    } chk_state_t;

    localparam int DBG_REG_AW = 5;
    localparam int DBG_MEM_AW = 10;

endpackage

// File: rtl/chk_compare_stage.sv
// rtl/chk_compare_stage.sv - registered compare, mismatch counter and first-fail capture
module chk_compare_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int IW         = 5,
    parameter int CW         = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  capture_valid,
    input  logic [IW-1:0]         capture_index,
    input  logic                  capture_sel,
    input  logic [DATA_WIDTH-1:0] dbg_reg_data,
    input  logic [DATA_WIDTH-1:0] dbg_mem_data,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic                  exp_care,
    output logic [CW-1:0]         mismatch_count,
    output logic                  first_fail_valid,
    output logic [IW-1:0]         first_fail_index,
    output logic [DATA_WIDTH-1:0] first_fail_got
);

    logic            valid_q;
    logic [IW-1:0]   index_q;
    logic            sel_q;
    logic [DATA_WIDTH-1:0] got;
    logic            mismatch;

    // Debug data and expected value both arrive one cycle after the address was issued.
    assign got      = sel_q ? dbg_mem_data : dbg_reg_data;
    assign mismatch = valid_q && exp_care && (got != exp_data);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q          <= 1'b0;
            index_q          <= '0;
            sel_q            <= 1'b0;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_index <= '0;
            first_fail_got   <= '0;
        end else if (clear) begin
            valid_q          <= 1'b0;
            index_q          <= '0;
            sel_q            <= 1'b0;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_index <= '0;
            first_fail_got   <= '0;
        end else begin
            valid_q <= capture_valid;
            index_q <= capture_index;
            sel_q   <= capture_sel;
            if (mismatch) begin
                mismatch_count <= mismatch_count + CW'(1);
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_index <= index_q;
                    first_fail_got   <= got;
                end
            end
        end
    end

endmodule

// File: rtl/mips_result_checker.sv
// rtl/mips_result_checker.sv - end-of-run checker: run/settle/scan FSM with debug-port sweep
module mips_result_checker
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 15,
    parameter int REG_FIRST      = 1,
    parameter int NUM_MEM        = 4,
    parameter int MEM_BASE_WORD  = 8,
    parameter int TIMEOUT_CYCLES = 90,
    parameter int SETTLE_CYCLES  = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic                                     halt,
    output logic [DBG_REG_AW-1:0]                    dbg_reg_addr,
    input  logic [DATA_WIDTH-1:0]                    dbg_reg_data,
    output logic [DBG_MEM_AW-1:0]                    dbg_mem_addr,
    input  logic [DATA_WIDTH-1:0]                    dbg_mem_data,
    output logic [$clog2(NUM_REGS+NUM_MEM)-1:0]      exp_index,
    input  logic [DATA_WIDTH-1:0]                    exp_data,
    input  logic                                     exp_care,
    output logic                                     done,
    output logic                                     pass,
    output logic                                     timeout,
    output logic [$clog2(NUM_REGS+NUM_MEM+1)-1:0]    mismatch_count,
    output logic                                     first_fail_valid,
    output logic [$clog2(NUM_REGS+NUM_MEM)-1:0]      first_fail_index,
    output logic [DATA_WIDTH-1:0]                    first_fail_got,
    output logic [31:0]                              cycle_count
);

    localparam int N  = NUM_REGS + NUM_MEM;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    chk_state_t    state, state_next;
    logic [15:0]   settle_cnt;
    logic          clear;
    logic          timeout_hit;
    logic [IW-1:0] scan_idx_load;

    assign clear       = start && (state == CHK_IDLE || state == CHK_DONE);
    // A halt in the same cycle as the timeout takes priority.
    assign timeout_hit = (state == CHK_RUN) && !halt && (cycle_count == 32'(TIMEOUT_CYCLES - 1));
    assign scan_idx_load = (state == CHK_SCAN) ? exp_index + IW'(1) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= CHK_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            CHK_IDLE, CHK_DONE: if (start) state_next = CHK_RUN;
            CHK_RUN: begin
                if (halt)             state_next = (SETTLE_CYCLES == 0) ? CHK_SCAN : CHK_SETTLE;
                else if (timeout_hit) state_next = CHK_SCAN;
            end
            CHK_SETTLE: if (settle_cnt == 16'd0) state_next = CHK_SCAN;
            CHK_SCAN:   if (exp_index == IW'(N - 1)) state_next = CHK_FLUSH;
            CHK_FLUSH:  state_next = CHK_DONE;
            default:    state_next = CHK_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count  <= '0;
            timeout      <= 1'b0;
            settle_cnt   <= '0;
            exp_index    <= '0;
            dbg_reg_addr <= '0;
            dbg_mem_addr <= '0;
        end else begin
            if (clear) begin
                cycle_count <= '0;
                timeout     <= 1'b0;
            end else if (state == CHK_RUN) begin
                if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
                if (timeout_hit)       timeout     <= 1'b1;
            end

            if (state == CHK_RUN && halt)
                settle_cnt <= 16'(SETTLE_CYCLES - 1);
            else if (state == CHK_SETTLE)
                settle_cnt <= settle_cnt - 16'd1;

            // Addresses are registered one step ahead so they hold outside the scan.
            if (state_next == CHK_SCAN) begin
                exp_index <= scan_idx_load;
                if (int'(scan_idx_load) < NUM_REGS)
                    dbg_reg_addr <= DBG_REG_AW'(REG_FIRST + int'(scan_idx_load));
                else
                    dbg_mem_addr <= DBG_MEM_AW'(MEM_BASE_WORD + int'(scan_idx_load) - NUM_REGS);
            end
        end
    end

    chk_compare_stage #(
        .DATA_WIDTH(DATA_WIDTH),
        .IW        (IW),
        .CW        (CW)
    ) u_compare (
        .clk             (clk),
        .reset           (reset),
        .clear           (clear),
        .capture_valid   (state == CHK_SCAN),
        .capture_index   (exp_index),
        .capture_sel     (int'(exp_index) >= NUM_REGS),
        .dbg_reg_data    (dbg_reg_data),
        .dbg_mem_data    (dbg_mem_data),
        .exp_data        (exp_data),
        .exp_care        (exp_care),
        .mismatch_count  (mismatch_count),
        .first_fail_valid(first_fail_valid),
        .first_fail_index(first_fail_index),
        .first_fail_got  (first_fail_got)
    );

    assign done = (state == CHK_DONE);
    assign pass = done && (mismatch_count == '0) && !timeout;

endmodule
